// File: rtl/ysyx_22040632_RISCV_PKG.sv
// Shared RISC-V core types: IFU FSM state, fetch buffer entry, fixed encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22040632_RISCV_PKG;

  // IFU fetch FSM. HALT is only ever entered when the ebreak-halt build is enabled.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } ifu_state_t;

  // One buffered fetch: the instruction together with the PC it came from.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040632_ifu_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the IFU only pushes when a credit was held, so push-when-full never happens.
module ysyx_22040632_ifu_fifo
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  fetch_entry_t       i_push_dat,
  input  logic               i_pop,
  input  logic               i_flush,
  output fetch_entry_t       o_head_dat,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_empty,
  output logic               o_full
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // Storage array: no reset, visibility is governed by r_count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers and occupancy; flush empties the buffer without touching storage.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == DEPTH_C);

endmodule

// File: rtl/ysyx_22040632_ifu.sv
// Instruction fetch: PC register, single-outstanding imem fetch, instruction buffer toward decode.
// Latency: request the cycle after reset release; response enters the buffer at its posedge, inst_valid the cycle after.
// Backpressure: a fetch is only requested while the buffer has a free slot; decode stalls hold inst/pc stable.
// Build option: define YSYX_22040632_IFU_EBREAK_HALT_EN to stop fetching after a buffered ebreak.
module ysyx_22040632_ifu
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] pc
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  ifu_state_t        r_state;
  logic [63:0]       r_fetch_pc;
  logic [63:0]       r_req_pc;
  logic              r_drop;

  fetch_entry_t      w_head;
  fetch_entry_t      w_push_dat;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_req_fire;
  logic [63:0]       w_redirect_pc;

  // Targets are forced to word alignment; masking keeps every redirect bit in use.
  assign w_redirect_pc = redirect_pc & ~64'h3;

  // Credit: only ask for an instruction if the buffer can still hold its response.
  assign imem_req_valid = !rst && (r_state == REQ) && (w_count < DEPTH_C);
  assign imem_req_addr  = rst ? RESET_PC : r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response is kept only if it was not marked stale and no redirect lands with it.
  assign w_push          = !rst && (r_state == WAIT) && imem_rsp_valid && !r_drop && !redirect_valid;
  assign w_push_dat.pc   = r_req_pc;
  assign w_push_dat.inst = imem_rsp_data;

  assign inst_valid = !rst && !w_empty;
  assign w_pop      = inst_valid && inst_ready;
  assign inst       = rst ? 32'h0 : w_head.inst;
  assign pc         = rst ? 64'h0 : w_head.pc;

`ifdef YSYX_22040632_IFU_EBREAK_HALT_EN
  logic w_halt_go;
  assign w_halt_go = w_push && (imem_rsp_data == EBREAK_INST);
`endif

  // Fetch FSM and PC: redirect overrides sequential advance and marks any in-flight fetch stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      if (w_req_fire) r_req_pc <= r_fetch_pc;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        case (r_state)
          REQ: begin
            if (w_req_fire) begin
              r_state <= WAIT;
              r_drop  <= 1'b1;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              r_state <= REQ;
              r_drop  <= 1'b0;
            end else begin
              r_drop  <= 1'b1;
            end
          end
          default: begin
            r_state <= REQ;
            r_drop  <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          REQ: begin
            if (w_req_fire) begin
              r_state    <= WAIT;
              r_fetch_pc <= r_fetch_pc + 64'd4;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              r_drop <= 1'b0;
`ifdef YSYX_22040632_IFU_EBREAK_HALT_EN
              r_state <= w_halt_go ? HALT : REQ;
`else
              r_state <= REQ;
`endif
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  ysyx_22040632_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // The credit rule makes a push into a full buffer unreachable.
  assert property (@(posedge clk) disable iff (rst) !(w_push && w_full && !w_pop));

endmodule

// File: doc/ysyx_22040632_ifu.md
Name: ysyx_22040632_ifu

Overview:
Instruction fetch unit. It sits directly upstream of the decode stage.
- Holds the PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request and valid-only response.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts PC redirects from execute (jal/jalr/branch), flushing any stale state.

Parameters:
RESET_PC, 64'h8000_0000, first fetch address after reset.
FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  synchronous, active-high reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  64  fetch address, always 4-byte aligned.
imem_rsp_valid  input  1  response data valid, one-cycle pulse.
imem_rsp_data  input  32  fetched instruction.
redirect_valid  input  1  execute requests new PC.
redirect_pc  input  64  redirect target.
inst_valid  output  1  inst/pc valid toward decode.
inst_ready  input  1  decode consumes this cycle.
inst  output  32  instruction to decode.
pc  output  64  PC of inst.

Behaviour:
- Reset state (rst=1 at posedge):
  - fetch_pc = RESET_PC; FSM = REQ; FIFO empty; drop flag = 0.
  - Outputs while in reset: imem_req_valid=0, inst_valid=0, inst=0, pc=0, imem_req_addr=RESET_PC.
  - Reset mid-transaction abandons any outstanding request. The first response after reset is not expected; the memory is reset with the IFU.
- FSM states:
  - REQ: imem_req_valid=1 when FIFO count + 0 outstanding < FIFO_DEPTH. On req handshake: go to WAIT, latch req_pc=fetch_pc, fetch_pc += 4.
  - WAIT: at most one request outstanding. On imem_rsp_valid:
    - If drop=0, enqueue {req_pc, imem_rsp_data}.
    - Clear drop; go to REQ.
  - HALT: see the optional feature.
- Credit rule: a request is issued only if count < FIFO_DEPTH. The response therefore always has room; FIFO overflow is impossible by construction.
- Latency:
  - Request issued the cycle after reset is released.
  - Response is written into the FIFO at the posedge where rsp_valid=1; inst_valid rises the following cycle. There is no rsp-to-decode bypass.
  - Best-case throughput is one instruction per 2 cycles with a 1-cycle memory.
- Decode handshake:
  - inst and pc come from the FIFO head and are stable while inst_valid=1 and inst_ready=0.
  - Dequeue occurs when inst_valid && inst_ready.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect (redirect_valid=1 at posedge), highest priority:
  - fetch_pc = {redirect_pc[63:2], 2'b00}.
  - FIFO flushed: count=0, and inst_valid=0 in the next cycle. A decode handshake in the redirect cycle still completes.
  - If in WAIT and imem_rsp_valid=0: drop=1, stay WAIT, and the next response is discarded.
  - If a response arrives in the redirect cycle: it is discarded; go to REQ.
  - If in REQ and the request handshakes in the redirect cycle: that request is treated as outstanding with drop=1; go to WAIT.
  - A redirect leaves HALT and goes to REQ.
- PC arithmetic: 64-bit, wraps modulo 2^64 silently.
- Pointers: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
Macro YSYX_22040632_IFU_EBREAK_HALT_EN.
- Defined: when an enqueued (not dropped) instruction equals 32'h0010_0073 (ebreak), the FSM enters HALT. No further requests are issued. The buffered ebreak still drains to decode. A redirect or reset exits HALT.
- Undefined: the HALT state and comparator are absent; fetch continues past ebreak.

Decomposition:
- Shared package ysyx_22040632_RISCV_PKG gains:
  - ifu_state_t enum {REQ, WAIT, HALT}.
  - fetch_entry_t packed struct {logic [63:0] pc; logic [31:0] inst}.
  - Constants EBREAK_INST = 32'h0010_0073 and RESET_PC_DEFAULT = 64'h8000_0000.
- One sub-module, ysyx_22040632_ifu_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full outputs.

Test Plan:
- Reset release with a 1-cycle memory returning addr-derived data, inst_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008; decode sees matching pc/inst, one instruction every 2 cycles.
- inst_ready=0 for 10 cycles, DEPTH=2 → exactly 2 requests issued; imem_req_valid then stays 0; inst/pc held stable. Releasing ready resumes fetch in order.
- Redirect to 0x80001002 while WAIT, response 3 cycles later → that response discarded; next request at 0x80001000; inst_valid=0 the cycle after the redirect.
- Redirect in the same cycle as imem_rsp_valid and a FIFO holding 1 entry → both dropped; next request at the target; no stale pc reaches decode.
- rst asserted mid-WAIT with 2 buffered entries → next cycle inst_valid=0; first request after release at RESET_PC.
- With HALT_EN, memory returns 0x00100073 at 0x80000008 → ebreak delivered with pc=0x80000008; no further imem_req_valid until redirect to 0x80000100, after which fetch resumes there.
